// File: rtl/btn_device_multi.sv
// Multi-channel push-button conditioner: 2-FF sync, tick-sampled hysteresis debounce,
// press/release edges, long-press and auto-repeat pulses per channel.
module btn_device_multi #(
  parameter int NUM_BTN      = 4,
  parameter int F_COUNT      = 1000,
  parameter int DB_DEPTH     = 8,
  parameter int LONG_TICKS   = 50000,
  parameter int REPEAT_TICKS = 10000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_BTN-1:0] i_btn,
  output logic [NUM_BTN-1:0] o_level,
  output logic [NUM_BTN-1:0] o_rise,
  output logic [NUM_BTN-1:0] o_fall,
  output logic [NUM_BTN-1:0] o_long,
  output logic [NUM_BTN-1:0] o_repeat
);

  localparam int CW = (F_COUNT > 1) ? $clog2(F_COUNT) : 1;
  localparam int HW = $clog2(LONG_TICKS + 1);
  localparam int RW = (REPEAT_TICKS > 0) ? $clog2(REPEAT_TICKS + 1) : 1;

  localparam logic [CW-1:0] CNT_MAX = CW'(F_COUNT - 1);
  localparam logic [HW-1:0] HOLD_MAX = HW'(LONG_TICKS);
  localparam logic [HW-1:0] HOLD_M1  = HW'(LONG_TICKS - 1);
  localparam logic [RW-1:0] REP_M1   = RW'((REPEAT_TICKS > 0) ? REPEAT_TICKS - 1 : 0);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          tick;

  logic [NUM_BTN-1:0]               sync1_q, sync2_q;
  logic [NUM_BTN-1:0][DB_DEPTH-1:0] sr_q, sr_d;
  logic [NUM_BTN-1:0]               level_q, level_d, level_dly_q;
  logic [NUM_BTN-1:0][HW-1:0]       hold_q, hold_d;
  logic [NUM_BTN-1:0][RW-1:0]       rep_q, rep_d;
  logic [NUM_BTN-1:0]               long_q, long_d;
  logic [NUM_BTN-1:0]               repeat_q, repeat_d;

  always_comb begin
    tick  = (cnt_q == CNT_MAX);
    cnt_d = tick ? '0 : cnt_q + 1'b1;
  end

  always_comb begin
    sr_d     = sr_q;
    level_d  = level_q;
    hold_d   = hold_q;
    rep_d    = rep_q;
    long_d   = '0;
    repeat_d = '0;
    for (int k = 0; k < NUM_BTN; k++) begin
      // Level follows the shift register the same edge the qualifying sample lands.
      if (tick) begin
        sr_d[k] = {sr_q[k][DB_DEPTH-2:0], sync2_q[k]};
        if (&sr_d[k])
          level_d[k] = 1'b1;
        else if (~|sr_d[k])
          level_d[k] = 1'b0;
      end

      if (!level_q[k]) begin
        hold_d[k] = '0;
        rep_d[k]  = '0;
      end else if (tick) begin
        if (hold_q[k] == HOLD_M1) begin
          hold_d[k] = HOLD_MAX;
          long_d[k] = 1'b1;
        end else if (hold_q[k] != HOLD_MAX) begin
          hold_d[k] = hold_q[k] + 1'b1;
        end

        if ((REPEAT_TICKS > 0) && (hold_q[k] == HOLD_MAX)) begin
          if (rep_q[k] == REP_M1) begin
            rep_d[k]    = '0;
            repeat_d[k] = 1'b1;
          end else begin
            rep_d[k] = rep_q[k] + 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q       <= '0;
      sync1_q     <= '0;
      sync2_q     <= '0;
      sr_q        <= '0;
      level_q     <= '0;
      level_dly_q <= '0;
      hold_q      <= '0;
      rep_q       <= '0;
      long_q      <= '0;
      repeat_q    <= '0;
    end else begin
      cnt_q       <= cnt_d;
      sync1_q     <= i_btn;
      sync2_q     <= sync1_q;
      sr_q        <= sr_d;
      level_q     <= level_d;
      level_dly_q <= level_q;
      hold_q      <= hold_d;
      rep_q       <= rep_d;
      long_q      <= long_d;
      repeat_q    <= repeat_d;
    end
  end

  assign o_level  = level_q;
  assign o_rise   = level_q & ~level_dly_q;
  assign o_fall   = ~level_q & level_dly_q;
  assign o_long   = long_q;
  assign o_repeat = repeat_q;

endmodule

// File: tb/tb_btn_device_multi.sv
// Directed bench for btn_device_multi: 2 channels, 4-clk tick, 4-sample debounce,
// long press at 8 ticks, repeat every 3 ticks.
module tb_btn_device_multi;

  localparam int NB = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic [NB-1:0] i_btn;
  logic [NB-1:0] o_level, o_rise, o_fall, o_long, o_repeat;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  int rise_n[NB], fall_n[NB], long_n[NB], rep_n[NB];
  int rise_t[NB], fall_t[NB], long_t[NB], rep_t[NB];

  btn_device_multi #(
    .NUM_BTN(NB), .F_COUNT(4), .DB_DEPTH(4), .LONG_TICKS(8), .REPEAT_TICKS(3)
  ) dut (
    .clk(clk), .rst(rst), .i_btn(i_btn),
    .o_level(o_level), .o_rise(o_rise), .o_fall(o_fall),
    .o_long(o_long), .o_repeat(o_repeat)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    for (int k = 0; k < NB; k++) begin
      rise_n[k] = 0; fall_n[k] = 0; long_n[k] = 0; rep_n[k] = 0;
      rise_t[k] = 0; fall_t[k] = 0; long_t[k] = 0; rep_t[k] = 0;
    end
  end

  // Pulse log: count and timestamp every output pulse per channel
  always @(negedge clk) begin
    if (rst) begin
      for (int k = 0; k < NB; k++) begin
        if (o_rise[k])   begin rise_n[k] <= rise_n[k] + 1; rise_t[k] <= cyc; end
        if (o_fall[k])   begin fall_n[k] <= fall_n[k] + 1; fall_t[k] <= cyc; end
        if (o_long[k])   begin long_n[k] <= long_n[k] + 1; long_t[k] <= cyc; end
        if (o_repeat[k]) begin rep_n[k]  <= rep_n[k] + 1;  rep_t[k]  <= cyc; end
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  function automatic int get_cnt(input int kind, input int ch);
    case (kind)
      0:       return rise_n[ch];
      1:       return long_n[ch];
      2:       return rep_n[ch];
      default: return fall_n[ch];
    endcase
  endfunction

  task automatic wait_level(input int ch, input logic v, input int max_clk, input string tag);
    int n = 0;
    while (o_level[ch] !== v && n < max_clk) begin
      step();
      n++;
    end
    check(tag, 32'(o_level[ch]), 32'(v));
  endtask

  task automatic wait_cnt(input int kind, input int ch, input int target, input int max_clk,
                          input string tag);
    int n = 0;
    while (get_cnt(kind, ch) < target && n < max_clk) begin
      step();
      n++;
    end
    check(tag, 32'(get_cnt(kind, ch)), 32'(target));
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0, rs0, rs1, fs, ls, ps, tp;

    // 1: reset with both buttons pressed
    rst   = 1'b0;
    i_btn = 2'b11;
    repeat (3) step();
    check("reset_outputs", 32'({o_level, o_rise, o_fall, o_long, o_repeat}), 32'd0);
    repeat (2) step();
    rst = 1'b1;
    c0  = cyc;
    repeat (12) step();
    check("t1_level_not_yet", 32'(o_level), 32'd0);
    wait_level(0, 1'b1, 10, "t1_level0_up");
    check("t1_both_up", 32'(o_level), 32'd3);
    repeat (2) step();
    check("t1_rise_latency", 32'(rise_t[0] - c0), 32'd16);
    check("t1_rise_simultaneous", 32'(rise_t[1]), 32'(rise_t[0]));
    i_btn = 2'b00;
    wait_level(0, 1'b0, 24, "t1_level0_down");
    check("t1_both_down", 32'(o_level), 32'd0);

    // 2: clean press / release on channel 0
    rs0 = rise_n[0]; fs = fall_n[0]; ls = long_n[0];
    i_btn[0] = 1'b1;
    wait_level(0, 1'b1, 20, "t2_press");
    repeat (3) step();
    check("t2_one_rise", 32'(rise_n[0] - rs0), 32'd1);
    check("t2_rise_ended", 32'(o_rise[0]), 32'd0);
    check("t2_ch1_quiet", 32'(o_level[1]), 32'd0);
    i_btn[0] = 1'b0;
    wait_level(0, 1'b0, 20, "t2_release");
    repeat (3) step();
    check("t2_one_fall", 32'(fall_n[0] - fs), 32'd1);
    check("t2_no_long", 32'(long_n[0] - ls), 32'd0);

    // 3: bouncing channel 1
    rs0 = rise_n[0]; rs1 = rise_n[1];
    for (int i = 0; i < 17; i++) begin
      i_btn[1] = ~i_btn[1];
      repeat (6) step();
    end
    check("t3_no_rise_bounce", 32'(rise_n[1] - rs1), 32'd0);
    check("t3_level_low_bounce", 32'(o_level[1]), 32'd0);
    wait_level(1, 1'b1, 24, "t3_settle");
    repeat (3) step();
    check("t3_one_rise", 32'(rise_n[1] - rs1), 32'd1);
    check("t3_ch0_quiet", 32'(rise_n[0] - rs0), 32'd0);
    i_btn[1] = 1'b0;
    wait_level(1, 1'b0, 24, "t3_release");

    // 4: long press and repeat on channel 0
    ls = long_n[0]; ps = rep_n[0];
    i_btn[0] = 1'b1;
    wait_level(0, 1'b1, 20, "t4_press");
    wait_cnt(1, 0, ls + 1, 40, "t4_long_seen");
    check("t4_long_delay", 32'(long_t[0] - rise_t[0]), 32'd32);
    wait_cnt(2, 0, ps + 1, 16, "t4_rep1_seen");
    check("t4_rep1_delay", 32'(rep_t[0] - long_t[0]), 32'd12);
    tp = rep_t[0];
    wait_cnt(2, 0, ps + 2, 16, "t4_rep2_seen");
    check("t4_rep2_period", 32'(rep_t[0] - tp), 32'd12);
    check("t4_long_once", 32'(long_n[0] - ls), 32'd1);
    i_btn[0] = 1'b0;
    wait_level(0, 1'b0, 20, "t4_release");
    ls = long_n[0]; ps = rep_n[0];
    repeat (60) step();
    check("t4_no_long_after", 32'(long_n[0] - ls), 32'd0);
    check("t4_no_rep_after", 32'(rep_n[0] - ps), 32'd0);

    // 5: short hold (level high for 5 ticks), then a fresh press
    rs0 = rise_n[0]; fs = fall_n[0]; ls = long_n[0];
    i_btn[0] = 1'b1;
    wait_level(0, 1'b1, 20, "t5_press");
    repeat (4) step();
    i_btn[0] = 1'b0;
    wait_level(0, 1'b0, 20, "t5_release");
    repeat (40) step();
    check("t5_hold_ticks", 32'(fall_t[0] - rise_t[0]), 32'd20);
    check("t5_rise", 32'(rise_n[0] - rs0), 32'd1);
    check("t5_fall", 32'(fall_n[0] - fs), 32'd1);
    check("t5_no_long", 32'(long_n[0] - ls), 32'd0);
    i_btn[0] = 1'b1;
    wait_level(0, 1'b1, 20, "t5_press2");
    wait_cnt(1, 0, ls + 1, 40, "t5_long2_seen");
    check("t5_long2_delay", 32'(long_t[0] - rise_t[0]), 32'd32);

    // 6: reset while repeat pulse is active, button still held
    ps = rep_n[0];
    wait_cnt(2, 0, ps + 1, 16, "t6_rep_seen");
    check("t6_rep_active", 32'(o_repeat[0]), 32'd1);
    rst = 1'b0;
    #1;
    check("t6_reset_immediate", 32'({o_level, o_rise, o_fall, o_long, o_repeat}), 32'd0);
    repeat (3) step();
    rst = 1'b1;
    c0  = cyc;
    ls  = long_n[0];
    wait_level(0, 1'b1, 20, "t6_requal");
    check("t6_rise_latency", 32'(rise_t[0] - c0), 32'd16);
    wait_cnt(1, 0, ls + 1, 40, "t6_long_seen");
    check("t6_long_delay", 32'(long_t[0] - rise_t[0]), 32'd32);
    i_btn[0] = 1'b0;
    wait_level(0, 1'b0, 20, "t6_release");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
